// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encodings and FSM state type
package alu_pkg;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/result bundle between ID/EX, the ALU and EX/MEM
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             valid_o;
  logic             busy_o;

  modport master (
    output valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, valid_o, busy_o
  );
endinterface

// File: rtl/multicycle_alu_shift_add_multiplier.sv
// rtl/multicycle_alu_shift_add_multiplier.sv - iterative shift-add multiplier, fixed WIDTH steps
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  // product includes the add of the final step so the top can register it on the done edge
  assign product  = acc_next;
  assign done     = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execute-stage ALU: single-cycle logic/arith ops plus multicycle MUL
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_alu_if.slave      bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mul_result;
  logic             mul_start, mul_clear, mul_done;

  shift_add_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (mul_clear),
    .start   (mul_start),
    .a       (bus.data1_i),
    .b       (bus.data2_i),
    .done    (mul_done),
    .product (mul_result)
  );

  always_comb begin
    alu_result = '0;
    case (bus.ALUCtrl_i)
      ALU_AND: alu_result = bus.data1_i & bus.data2_i;
      ALU_OR:  alu_result = bus.data1_i | bus.data2_i;
      ALU_ADD: alu_result = bus.data1_i + bus.data2_i;
      ALU_SUB: alu_result = bus.data1_i - bus.data2_i;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    mul_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_i) begin
          mul_clear = 1'b1;
        end else if (bus.valid_i) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            data_d  = alu_result;
            zero_d  = (alu_result == '0);
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // requests arriving during MUL are not accepted, even on the finishing edge
        if (bus.flush_i) begin
          mul_clear = 1'b1;
          state_d   = S_IDLE;
        end else if (mul_done) begin
          data_d  = mul_result;
          zero_d  = (mul_result == '0);
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q == S_MUL);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu against an arithmetic model
module tb_multicycle_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    case (code)
      3'b001: return a & b;
      3'b010: return a | b;
      3'b011: return a + b;
      3'b100: return a - b;
      3'b101: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic v, input logic f, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i   = v;
    bus.flush_i   = f;
    bus.ALUCtrl_i = code;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  task automatic single_op(input string tag, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    e = ref_op(code, a, b);
    apply(1'b1, 1'b0, code, a, b);
    tick();
    check({tag, "_valid"}, {31'b0, bus.valid_o}, 32'd1);
    check({tag, "_data"}, bus.data_o, e);
    check({tag, "_zero"}, {31'b0, bus.zero_o}, {31'b0, e == 32'h0});
    check({tag, "_busy"}, {31'b0, bus.busy_o}, 32'd0);
    last_data = e;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int busy_cycles;
    int stray;
    logic [31:0] e;
    e = ref_op(3'b101, a, b);
    busy_cycles = 0;
    stray = 0;
    apply(1'b1, 1'b0, 3'b101, a, b);
    tick();
    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    while (bus.busy_o && busy_cycles < 40) begin
      busy_cycles++;
      if (bus.valid_o) stray++;
      if (bus.data_o !== last_data) stray++;
      tick();
    end
    check({tag, "_busy_cycles"}, busy_cycles, 32'd32);
    check({tag, "_stray"}, stray, 32'd0);
    check({tag, "_valid"}, {31'b0, bus.valid_o}, 32'd1);
    check({tag, "_data"}, bus.data_o, e);
    check({tag, "_zero"}, {31'b0, bus.zero_o}, {31'b0, e == 32'h0});
    last_data = e;
    tick();
    check({tag, "_pulse_end"}, {31'b0, bus.valid_o}, 32'd0);
  endtask

  initial begin
    int busy_cycles;
    int stray;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;

    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data", bus.data_o, 32'h0);
    check("rst_zero", {31'b0, bus.zero_o}, 32'd1);
    check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    last_data = 32'h0;

    single_op("add", 3'b011, 32'd7, 32'd5);
    single_op("sub", 3'b100, 32'd5, 32'd7);
    single_op("and", 3'b001, 32'h0000_F0F0, 32'h0000_FF00);
    single_op("or", 3'b010, 32'h0000_000F, 32'h0000_00F0);
    single_op("sub_zero", 3'b100, 32'd9, 32'd9);
    single_op("add_mid", 3'b011, 32'd1, 32'd2);
    single_op("nop111", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
    single_op("nop110", 3'b110, 32'hFFFF_FFFF, 32'h1);
    single_op("add_wrap", 3'b011, 32'hFFFF_FFFF, 32'h1);

    for (int i = 0; i < 24; i++) begin
      code = 3'($urandom_range(0, 7));
      if (code == 3'b101) code = 3'b011;
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      single_op("rand_op", code, a, b);
    end

    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("idle_no_valid", {31'b0, bus.valid_o}, 32'd0);
    check("idle_hold_data", bus.data_o, last_data);

    run_mul("mul_6x7", 32'd6, 32'd7);
    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mul_ovf_zero", 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 4; i++) begin
      run_mul("mul_rand", $urandom, $urandom);
    end

    // stall: ADD held on the bus for the whole multiply
    apply(1'b1, 1'b0, 3'b101, 32'd3, 32'd4);
    tick();
    apply(1'b1, 1'b0, 3'b011, 32'd1, 32'd1);
    busy_cycles = 0;
    stray = 0;
    while (bus.busy_o && busy_cycles < 40) begin
      busy_cycles++;
      if (bus.valid_o) stray++;
      tick();
    end
    check("stall_busy_cycles", busy_cycles, 32'd32);
    check("stall_stray", stray, 32'd0);
    check("stall_mul_valid", {31'b0, bus.valid_o}, 32'd1);
    check("stall_mul_data", bus.data_o, ref_op(3'b101, 32'd3, 32'd4));
    tick();
    check("stall_add_valid", {31'b0, bus.valid_o}, 32'd1);
    check("stall_add_data", bus.data_o, ref_op(3'b011, 32'd1, 32'd1));
    check("stall_add_busy", {31'b0, bus.busy_o}, 32'd0);
    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("stall_no_dup", {31'b0, bus.valid_o}, 32'd0);
    last_data = 32'd2;

    // flush at multiply cycle 10
    apply(1'b1, 1'b0, 3'b101, 32'd100, 32'd200);
    tick();
    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    check("flush_pre_busy", {31'b0, bus.busy_o}, 32'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_busy", {31'b0, bus.busy_o}, 32'd0);
    check("flush_valid", {31'b0, bus.valid_o}, 32'd0);
    check("flush_data", bus.data_o, last_data);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o || bus.busy_o) stray++;
    end
    check("flush_quiet", stray, 32'd0);

    // flush beats a same-edge request in IDLE
    apply(1'b1, 1'b1, 3'b011, 32'd10, 32'd20);
    tick();
    check("flush_idle_valid", {31'b0, bus.valid_o}, 32'd0);
    check("flush_idle_data", bus.data_o, last_data);
    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("flush_idle_after", {31'b0, bus.valid_o}, 32'd0);

    // reset in the middle of a multiply
    apply(1'b1, 1'b0, 3'b101, 32'd55, 32'd66);
    tick();
    apply(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_mul_data", bus.data_o, 32'h0);
    check("rst_mul_zero", {31'b0, bus.zero_o}, 32'd1);
    check("rst_mul_valid", {31'b0, bus.valid_o}, 32'd0);
    check("rst_mul_busy", {31'b0, bus.busy_o}, 32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o || bus.busy_o) stray++;
    end
    check("rst_mul_quiet", stray, 32'd0);

    single_op("post_rst_add", 3'b011, 32'd40, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
